regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter LOCK_TMO, default 8, SHALL set the lock-release idle timeout in cycles (1..255).
REQ-003 clk  input  1  SHALL be the sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  SHALL flag, per requester, a pending write.
REQ-006 req_lock  input  NREQ  SHALL request, per requester, that the grant be held after this transfer.
REQ-007 req_wreg  input  NREQ*5  SHALL carry the packed destination register numbers; requester i uses bits [5i+4:5i].
REQ-008 req_wdata  input  NREQ*32  SHALL carry the packed write data; requester i uses bits [32i+31:32i].
REQ-009 req_ready  output  NREQ  SHALL be the combinational, at-most-one-hot accept for the current cycle.
REQ-010 rf_write  output  1  SHALL be the registered write enable to the 32x32 register file.
REQ-011 rf_wreg  output  5  SHALL be the registered register number to the register file.
REQ-012 rf_wdata  output  32  SHALL be the registered write data to the register file.
REQ-013 lock_owner  output  3  SHALL give the index of the current lock owner; value is 0 when unlocked.
REQ-014 locked  output  1  SHALL be high while in state LOCKED.

Function
REQ-015 A transfer SHALL occur on requester i in a cycle when req_valid[i] and req_ready[i] are both high; at most one transfer per cycle.
REQ-016 State IDLE: req_ready SHALL go to the first valid requester, searching circularly from rr_ptr.
REQ-017 State LOCKED: req_ready SHALL go only to lock_owner, and only when that owner's req_valid is high; all other ready bits SHALL be 0.
REQ-018 After a transfer on requester i, rf_write SHALL be 1 on the next cycle, with rf_wreg/rf_wdata equal to i's inputs; latency SHALL be exactly 1 cycle.
REQ-019 rf_write SHALL be 0 in any cycle that does not follow a transfer.
REQ-020 rr_ptr SHALL update to (i+1) mod NREQ after any transfer; after a transfer from NREQ-1 it SHALL wrap to 0.
REQ-021 IDLE->LOCKED SHALL occur on a transfer with req_lock[i]=1; lock_owner SHALL be set to i.
REQ-022 LOCKED->IDLE SHALL occur on an owner transfer with req_lock=0, the final write still being issued.
REQ-023 In LOCKED, an idle counter SHALL increment on each cycle the owner's req_valid is 0 and clear on each owner transfer.
REQ-024 When the idle counter reaches LOCK_TMO, the block SHALL return to IDLE on that edge, with rr_ptr set to owner+1.
REQ-025 req_ready SHALL not depend on any rf_* output; the arbiter SHALL never stall (one accept per cycle sustained).
REQ-026 No valid requesters SHALL result in req_ready=0, with state and rr_ptr unchanged.

Reset
REQ-027 While rst is high: req_ready=0, rf_write=0, rf_wreg=0, rf_wdata=0, locked=0, lock_owner=0, rr_ptr=0, idle counter=0, state IDLE.
REQ-028 Reset asserted mid-operation SHALL drop a write accepted in the prior cycle (rf_write forced 0) and release any lock.
REQ-029 After rst deasserts, requester 0 SHALL have first priority.

Configuration
REQ-030 With macro REGFILE_R0_PROTECT_EN defined, a transfer with wreg=0 SHALL be accepted normally (ready, pointer and lock all update) but SHALL issue rf_write=0 on the next cycle.
REQ-031 With REGFILE_R0_PROTECT_EN undefined, writes to register 0 SHALL be issued like any other write.

Verification
REQ-032 Requesters 0,1,2,3 all valid and continuously held -> grants 0,1,2,3,0 on consecutive cycles; rf_write=1 on each following cycle.
REQ-033 Requester 2 writes wreg=7, wdata=0xDEADBEEF with lock=1, then 3 more transfers with lock=1 and a last one with lock=0, while requester 0 is valid throughout -> only 2 is granted until its release; requester 0 is granted on the next cycle.
REQ-034 Requester 1 locks and then holds valid=0 for 8 cycles (LOCK_TMO=8) -> locked drops on cycle 8; requester 2 (valid) is granted next.
REQ-035 rst pulsed one cycle after a transfer of wreg=5 -> rf_write stays 0 and all outputs return to 0.
REQ-036 Write to wreg=0 with data 0x1 -> rf_write=0 if REGFILE_R0_PROTECT_EN is defined, rf_write=1 otherwise; the grant occurs in both cases.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter feeding a 32x32 register file, with per-requester lock and idle-timeout release.
// Optional: define REGFILE_R0_PROTECT_EN to suppress the register-file write for transfers targeting r0.
module regfile_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int LOCK_TMO = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*5-1:0]  req_wreg,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_write,
  output logic [4:0]         rf_wreg,
  output logic [31:0]        rf_wdata,
  output logic [2:0]         lock_owner,
  output logic               locked
);

  // Handshake: a transfer on requester i happens in a cycle where req_valid[i] && req_ready[i];
  // req_ready is combinational from req_valid and internal state only, and is at most one-hot.

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t      state, state_nx;
  logic [2:0]  rr_ptr, rr_ptr_nx, owner_nx;
  logic [7:0]  idle_cnt, idle_cnt_nx;
  logic [2:0]  gidx;
  logic        xfer;
  logic        g_lock;
  logic [4:0]  g_wreg;
  logic [31:0] g_wdata;
  logic        wr_nx;

  function automatic logic [2:0] inc_mod(input logic [2:0] v);
    return (int'(v) == NREQ - 1) ? 3'd0 : v + 3'd1;
  endfunction

  // Grant selection: locked owner only, otherwise first valid requester at or after rr_ptr.
  always_comb begin
    req_ready = '0;
    gidx      = 3'd0;
    xfer      = 1'b0;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        for (int i = 0; i < NREQ; i++) begin
          if (int'(lock_owner) == i && req_valid[i]) begin
            req_ready[i] = 1'b1;
            gidx         = 3'(i);
            xfer         = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          for (int i = 0; i < NREQ; i++) begin
            if (!xfer && req_valid[i] && ((int'(rr_ptr) + k) % NREQ == i)) begin
              req_ready[i] = 1'b1;
              gidx         = 3'(i);
              xfer         = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    g_lock  = 1'b0;
    g_wreg  = 5'd0;
    g_wdata = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gidx) == i) begin
        g_lock  = req_lock[i];
        g_wreg  = req_wreg[i*5 +: 5];
        g_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

`ifdef REGFILE_R0_PROTECT_EN
  assign wr_nx = xfer && (g_wreg != 5'd0);
`else
  assign wr_nx = xfer;
`endif

  always_comb begin
    state_nx    = state;
    owner_nx    = lock_owner;
    idle_cnt_nx = idle_cnt;
    rr_ptr_nx   = rr_ptr;
    if (xfer) rr_ptr_nx = inc_mod(gidx);
    case (state)
      ST_IDLE: begin
        if (xfer && g_lock) begin
          state_nx    = ST_LOCKED;
          owner_nx    = gidx;
          idle_cnt_nx = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          idle_cnt_nx = 8'd0;
          if (!g_lock) begin
            state_nx = ST_IDLE;
            owner_nx = 3'd0;
          end
        end else if (int'(idle_cnt) + 1 >= LOCK_TMO) begin
          // Owner went quiet too long: release and resume after the owner.
          state_nx    = ST_IDLE;
          owner_nx    = 3'd0;
          idle_cnt_nx = 8'd0;
          rr_ptr_nx   = inc_mod(lock_owner);
        end else begin
          idle_cnt_nx = idle_cnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= 3'd0;
      idle_cnt   <= 8'd0;
      lock_owner <= 3'd0;
      rf_write   <= 1'b0;
      rf_wreg    <= 5'd0;
      rf_wdata   <= 32'd0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_ptr_nx;
      idle_cnt   <= idle_cnt_nx;
      lock_owner <= owner_nx;
      rf_write   <= wr_nx;
      if (xfer) begin
        rf_wreg  <= g_wreg;
        rf_wdata <= g_wdata;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, checked by a reference model
// and a write scoreboard. Define REGFILE_R0_PROTECT_EN here too when building the protected variant.
module tb_regfile_write_arbiter;
  localparam int NREQ     = 4;
  localparam int LOCK_TMO = 8;
  localparam int W        = 53;  // {cycle stamp[15:0], wreg[4:0], wdata[31:0]}

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*5-1:0]  req_wreg;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic               rf_write;
  logic [4:0]         rf_wreg;
  logic [31:0]        rf_wdata;
  logic [2:0]         lock_owner;
  logic               locked;

  regfile_write_arbiter #(.NREQ(NREQ), .LOCK_TMO(LOCK_TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock), .req_wreg(req_wreg), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rf_write(rf_write), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .lock_owner(lock_owner), .locked(locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  bit m_locked;
  int m_owner, m_ptr, m_idle;
  int obs_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit exp_write(input logic [4:0] r);
`ifdef REGFILE_R0_PROTECT_EN
    return r != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_idle();
    req_valid = '0;
    req_lock  = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit lk, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]        = v;
    req_lock[i]         = lk;
    req_wreg[i*5 +: 5]  = r;
    req_wdata[i*32 +: 32] = d;
  endtask

  // One clock of stimulus: predict the grant, compare, advance the model.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    logic [4:0] r;
    @(negedge clk);
    g = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("locked", locked, m_locked);
    chk("lock_owner", lock_owner, m_owner);
    obs_grant = g;
    if (g >= 0) begin
      r = req_wreg[g*5 +: 5];
      if (exp_write(r)) exp_q.push_back({16'(cyc + 1), r, req_wdata[g*32 +: 32]});
      m_ptr = (g + 1) % NREQ;
      if (!m_locked && req_lock[g]) begin
        m_locked = 1; m_owner = g; m_idle = 0;
      end else if (m_locked) begin
        m_idle = 0;
        if (!req_lock[g]) begin m_locked = 0; m_owner = 0; end
      end
    end else if (m_locked) begin
      m_idle++;
      if (m_idle == LOCK_TMO) begin
        m_ptr = (m_owner + 1) % NREQ; m_locked = 0; m_owner = 0; m_idle = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, '0);
      chk("rst_rf_write", rf_write, 0);
      chk("rst_rf_wreg", rf_wreg, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_locked", locked, 0);
      chk("rst_lock_owner", lock_owner, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // monitor: every issued write must match the head of the expected queue, stamped for this cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rf_write) begin
      if (exp_q.size() == 0) begin
        chk("rf_write_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_latency", 64'(16'(cyc)), 64'(e[52:37]));
        chk("rf_wreg", rf_wreg, e[36:32]);
        chk("rf_wdata", rf_wdata, e[31:0]);
      end
    end else if (exp_q.size() > 0 && exp_q[0][52:37] <= 16'(cyc)) begin
      e = exp_q.pop_front();
      chk("rf_write_missing", 0, 1);
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_lock = '0; req_wreg = '0; req_wdata = '0;
    do_reset(2);

    // round robin with all requesters held valid; requester 0 first after reset
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 5'(i + 10), 32'h1000 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq", obs_grant, k % 4);
    end

    // requester 2 holds a lock across 4 locked transfers and 1 releasing transfer
    set_idle();
    set_req(0, 1, 0, 5'd3, 32'hAAAA0000);
    set_req(2, 1, 1, 5'd7, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lock_grant", obs_grant, 2);
      chk("lock_held", locked, 1);
      set_req(2, 1, 1, 5'(8 + k), 32'hBEEF0000 + k);
    end
    set_req(2, 1, 0, 5'd12, 32'hCAFE0002);
    step();
    chk("lock_last", obs_grant, 2);
    chk("lock_released", locked, 0);
    set_req(2, 0, 0, 5'd0, 32'h0);
    step();
    chk("after_release", obs_grant, 0);

    // lock by requester 1, then idle timeout while requester 2 waits
    set_idle();
    set_req(1, 1, 1, 5'd20, 32'h11111111);
    step();
    chk("tmo_lock", obs_grant, 1);
    set_req(1, 0, 0, 5'd20, 32'h0);
    set_req(2, 1, 0, 5'd21, 32'h22222222);
    for (int j = 1; j <= LOCK_TMO; j++) begin
      step();
      if (j == LOCK_TMO - 1) chk("tmo_still_locked", locked, 1);
      if (j == LOCK_TMO)     chk("tmo_dropped", locked, 0);
    end
    step();
    chk("tmo_next_grant", obs_grant, 2);

    // random traffic with periodic quiet stretches to exercise timeouts
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), $urandom);
      if ((n / 40) % 4 == 3 && n % 40 < 10) req_valid = '0;
      step();
    end

    // reset one cycle after a locked transfer of wreg=5
    set_idle();
    set_req(3, 1, 1, 5'd9, 32'h99);
    step();
    set_req(3, 1, 1, 5'd5, 32'h55);
    step();
    set_idle();
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 5'd4, 32'h44 + i);
    step();
    chk("post_rst_grant", obs_grant, 0);

    // write to r0
    set_idle();
    set_req(1, 1, 0, 5'd0, 32'h1);
    step();
    chk("r0_grant", obs_grant, 1);
    set_idle();
    for (int k = 0; k < 3; k++) step();

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
